sr_bank_driver: RTL and testbench

- Initiator-side controller for a bank of WIDTH SR flip-flops (the existing SR_FF cell, replicated per bit).
- Accepts a target-value request over a valid/ready handshake and derives per-bit S/R excitation from the bank's current Q.
- Pulses S/R for one cycle, waits a settle window, then reads Q back and compares it against the target.
- Retries on mismatch up to a limit, then reports done with a pass/fail flag and a per-bit error mask.

---
 rtl/sr_pkg.sv | 27 ++
 rtl/sr_excite.sv | 17 +
 rtl/sr_bank_driver.sv | 159 +++++++++++++++
 tb/tb_sr_bank_driver.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared types and constants for the SR flip-flop bank initiator.
// Latency: none (declarations only).
// Backpressure: not applicable.
package sr_pkg;

    // Controller states: one drive pulse, a settle window, one readback check, one completion cycle
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Retry counter covers MAX_RETRY up to 15
    localparam int RETRY_W  = 4;
    // Settle counter; SETTLE_CYCLES must fit in this width
    localparam int SETTLE_W = 16;
    // Width of the optional statistics counters
    localparam int STAT_W   = 16;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sr_excite.sv
// Per-bit SR excitation: set bits that must rise, reset bits that must fall, hold the rest.
// Latency: combinational.
// Backpressure: none; pure function of target and current Q.
module sr_excite #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r
);

    // S and R are mutually exclusive per bit by construction, so S=R=1 never appears
    assign s = target & ~q;
    assign r = ~target & q;

endmodule

// File: rtl/sr_bank_driver.sv
// Drives an SR flip-flop bank to a requested value, verifies readback and retries on mismatch.
// Latency: done in the (SETTLE_CYCLES+3)th cycle after the handshake; each retry adds SETTLE_CYCLES+2.
// Backpressure: req_ready only in IDLE; requests presented while busy are not queued.
// Optional SR_DRV_STATS_EN adds saturating stat_ops/stat_fail completion counters.
module sr_bank_driver
    import sr_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 1,
    parameter int MAX_RETRY     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_target,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] s_out,
    output logic [WIDTH-1:0] r_out,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_mask,
    output logic             busy
`ifdef SR_DRV_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_ops,
    output logic [STAT_W-1:0] stat_fail
`endif
);

    localparam logic [RETRY_W-1:0]  RETRY_MAX   = RETRY_W'(MAX_RETRY);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    state_t              state;
    state_t              state_nx;
    logic [WIDTH-1:0]    target_q;
    logic [RETRY_W-1:0]  retry_cnt;
    logic [SETTLE_W-1:0] settle_cnt;

    logic [WIDTH-1:0]    exc_target;
    logic [WIDTH-1:0]    exc_s;
    logic [WIDTH-1:0]    exc_r;
    logic                accept;
    logic                mismatch;
    logic                finish;

    logic [WIDTH-1:0]    s_nx;
    logic [WIDTH-1:0]    r_nx;
    logic                done_nx;
    logic                err_nx;
    logic [WIDTH-1:0]    mask_nx;

    assign accept    = (state == ST_IDLE) && req_valid;
    assign mismatch  = (q_in != target_q);
    assign req_ready = (state == ST_IDLE);
    assign finish    = (state == ST_CHECK) && (state_nx == ST_DONE);

    // On acceptance the excitation must come from the incoming target; on retry from the latched one
    assign exc_target = (state == ST_IDLE) ? req_target : target_q;

    sr_excite #(.WIDTH(WIDTH)) u_excite (
        .target (exc_target),
        .q      (q_in),
        .s      (exc_s),
        .r      (exc_r)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (req_valid) state_nx = ST_DRIVE;
            ST_DRIVE:  state_nx = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_nx = ST_CHECK;
            ST_CHECK: begin
                if (!mismatch)                  state_nx = ST_DONE;
                else if (retry_cnt < RETRY_MAX) state_nx = ST_DRIVE;
                else                            state_nx = ST_DONE;
            end
            ST_DONE:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, keyed on the state being entered
    always_comb begin
        s_nx    = '0;
        r_nx    = '0;
        done_nx = 1'b0;
        err_nx  = 1'b0;
        mask_nx = err_mask;
        if (state_nx == ST_DRIVE) begin
            s_nx = exc_s;
            r_nx = exc_r;
        end
        if (finish) begin
            done_nx = 1'b1;
            err_nx  = mismatch;
            mask_nx = q_in ^ target_q;
        end
    end

    // Output registers; err_mask persists until the next completion or reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s_out    <= '0;
            r_out    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_mask <= '0;
            busy     <= 1'b0;
        end else begin
            s_out    <= s_nx;
            r_out    <= r_nx;
            done     <= done_nx;
            err      <= err_nx;
            err_mask <= mask_nx;
            busy     <= (state_nx != ST_IDLE);
        end
    end

    // Latched target, retry count and settle-window counter
    always_ff @(posedge clk) begin
        if (rst) begin
            target_q   <= '0;
            retry_cnt  <= '0;
            settle_cnt <= '0;
        end else begin
            if (accept) begin
                target_q  <= req_target;
                retry_cnt <= '0;
            end else if ((state == ST_CHECK) && (state_nx == ST_DRIVE)) begin
                retry_cnt <= retry_cnt + 1'b1;
            end
            if (state == ST_SETTLE) settle_cnt <= settle_cnt + 1'b1;
            else                    settle_cnt <= '0;
        end
    end

`ifdef SR_DRV_STATS_EN
    // Completion and failure counters, updated together with the done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops  <= '0;
            stat_fail <= '0;
        end else if (finish) begin
            stat_ops <= sat_inc(stat_ops);
            if (mismatch) stat_fail <= sat_inc(stat_fail);
        end
    end
`endif

endmodule

// File: tb/tb_sr_bank_driver.sv
// Directed bench for sr_bank_driver with default parameters (WIDTH=8, SETTLE_CYCLES=1, MAX_RETRY=2).
// Outputs are sampled 1 time unit after each rising edge; cycle 1 is the DRIVE cycle after a handshake.
// Statistics checks are compiled only when SR_DRV_STATS_EN is defined.
module tb_sr_bank_driver;
    import sr_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_target;
    logic [7:0] q_in;
    logic [7:0] s_out;
    logic [7:0] r_out;
    logic       done;
    logic       err;
    logic [7:0] err_mask;
    logic       busy;
`ifdef SR_DRV_STATS_EN
    logic [STAT_W-1:0] stat_ops;
    logic [STAT_W-1:0] stat_fail;
`endif

    int errors = 0;
    int checks = 0;

    sr_bank_driver #(.WIDTH(8), .SETTLE_CYCLES(1), .MAX_RETRY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_target (req_target),
        .q_in       (q_in),
        .s_out      (s_out),
        .r_out      (r_out),
        .done       (done),
        .err        (err),
        .err_mask   (err_mask),
        .busy       (busy)
`ifdef SR_DRV_STATS_EN
        ,
        .stat_ops   (stat_ops),
        .stat_fail  (stat_fail)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One-edge handshake: present the request for a single rising edge
    task automatic handshake(input logic [7:0] t);
        req_target = t;
        req_valid  = 1'b1;
        tick();
        req_valid  = 1'b0;
    endtask

    // S=R=1 must never be driven onto the bank
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            assert ((s_out & r_out) === 8'h00) else begin
                errors++;
                $error("FAIL sr_exclusive observed=%h expected=00", s_out & r_out);
            end
        end
    end

    initial begin
        int drives;
        int done_at;
        int done_cnt;
        int ready_cnt;
        int first_done;
        logic e_at;
        logic [7:0] m_at;

        rst = 1'b1; req_valid = 1'b0; req_target = 8'h00; q_in = 8'h00;

        // ---- reset state ----
        tick(); tick();
        chk("rst_s_out",    s_out,     8'h00);
        chk("rst_r_out",    r_out,     8'h00);
        chk("rst_done",     done,      1'b0);
        chk("rst_err",      err,       1'b0);
        chk("rst_err_mask", err_mask,  8'h00);
        chk("rst_busy",     busy,      1'b0);
        chk("rst_ready",    req_ready, 1'b1);
`ifdef SR_DRV_STATS_EN
        chk("rst_stat_ops",  stat_ops,  16'd0);
        chk("rst_stat_fail", stat_fail, 16'd0);
`endif
        rst = 1'b0;
        tick();

        // ---- q=00 -> A5: pure set, done in cycle 4 ----
        q_in = 8'h00;
        handshake(8'hA5);
        chk("t1_drive_s",   s_out,     8'hA5);
        chk("t1_drive_r",   r_out,     8'h00);
        chk("t1_busy",      busy,      1'b1);
        chk("t1_ready",     req_ready, 1'b0);
        q_in = 8'hA5;
        tick();
        chk("t1_settle_s",  s_out,     8'h00);
        tick();
        chk("t1_check_done", done,     1'b0);
        tick();
        chk("t1_done",      done,      1'b1);
        chk("t1_err",       err,       1'b0);
        chk("t1_mask",      err_mask,  8'h00);
        tick();
        chk("t1_idle_done", done,      1'b0);
        chk("t1_idle_ready", req_ready, 1'b1);
        chk("t1_idle_busy", busy,      1'b0);

        // ---- q=FF -> 0F: pure reset ----
        q_in = 8'hFF;
        handshake(8'h0F);
        chk("t2_drive_s",   s_out,     8'h00);
        chk("t2_drive_r",   r_out,     8'hF0);
        q_in = 8'h0F;
        tick(); tick(); tick();
        chk("t2_done",      done,      1'b1);
        chk("t2_err",       err,       1'b0);
        tick();

        // ---- stuck bank: q stays 00, target 01 -> 3 drives, fail in cycle 10 ----
        q_in = 8'h00;
        handshake(8'h01);
        drives = 0; done_at = 0; e_at = 1'b0; m_at = 8'h00;
        for (int c = 1; c <= 12; c++) begin
            if (s_out == 8'h01) drives++;
            if (done && done_at == 0) begin
                done_at = c;
                e_at    = err;
                m_at    = err_mask;
            end
            tick();
        end
        chk("stuck_drives",  drives,  3);
        chk("stuck_done_at", done_at, 10);
        chk("stuck_err",     e_at,    1'b1);
        chk("stuck_mask",    m_at,    8'h01);
        chk("stuck_err_drop", err,    1'b0);
        chk("stuck_mask_hold", err_mask, 8'h01);

        // ---- partial success, retry recomputes from current Q ----
        q_in = 8'h00;
        handshake(8'hF0);
        chk("retry_drive1_s", s_out, 8'hF0);
        q_in = 8'h30;
        tick(); tick(); tick();
        chk("retry_drive2_s", s_out, 8'hC0);
        chk("retry_drive2_r", r_out, 8'h00);
        q_in = 8'hF0;
        tick(); tick();
        chk("retry_pre_done", done, 1'b0);
        tick();
        chk("retry_done",   done,     1'b1);
        chk("retry_err",    err,      1'b0);
        chk("retry_mask",   err_mask, 8'h00);
        tick();

        // ---- req_valid held high, target already equals Q ----
        q_in = 8'h3C; req_target = 8'h3C; req_valid = 1'b1;
        done_cnt = 0; ready_cnt = 0; first_done = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) begin
                chk("held_hold_s", s_out, 8'h00);
                chk("held_hold_r", r_out, 8'h00);
                chk("held_busy",   busy,  1'b1);
            end
            if (done) begin
                done_cnt++;
                if (first_done == 0) first_done = c;
            end
            if (req_ready) ready_cnt++;
        end
        req_valid = 1'b0;
        chk("held_done_cnt",  done_cnt,   2);
        chk("held_first_done", first_done, 4);
        chk("held_ready_cnt", ready_cnt,  2);
        tick();
`ifdef SR_DRV_STATS_EN
        chk("stat_ops_6",  stat_ops,  16'd6);
        chk("stat_fail_1", stat_fail, 16'd1);
`endif

        // ---- reset during SETTLE aborts without a done pulse ----
        q_in = 8'h00;
        handshake(8'h81);
        chk("abort_drive_s", s_out, 8'h81);
        tick();
        chk("abort_in_settle", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_s",     s_out,     8'h00);
        chk("abort_r",     r_out,     8'h00);
        chk("abort_busy",  busy,      1'b0);
        chk("abort_ready", req_ready, 1'b1);
        chk("abort_done",  done,      1'b0);
`ifdef SR_DRV_STATS_EN
        chk("abort_stat_ops",  stat_ops,  16'd0);
        chk("abort_stat_fail", stat_fail, 16'd0);
`endif
        done_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (done) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 0);

        // ---- fresh request after abort completes normally ----
        handshake(8'h81);
        chk("fresh_drive_s", s_out, 8'h81);
        q_in = 8'h81;
        tick(); tick(); tick();
        chk("fresh_done", done, 1'b1);
        chk("fresh_err",  err,  1'b0);
        tick();
`ifdef SR_DRV_STATS_EN
        chk("fresh_stat_ops",  stat_ops,  16'd1);
        chk("fresh_stat_fail", stat_fail, 16'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
